simd_exec_sequencer: RTL and testbench
======================================

Name: simd_exec_sequencer

Overview:
- Sequences multi-cycle SIMD vector ops in the Execute stage of the 5-stage RISC pipeline.
- Splits each vector op of up to LANES elements into groups of HW_LANES and issues them to the shared MAC array. Waits out the array latency, then releases the pipeline.
- Drives the F/D/E stall and the lane-select/accumulator controls. Scalar ops pass through with no added cycles.

Parameters:
- LANES, 8: architectural vector length (elements); power of two.
- HW_LANES, 2: physical MAC lanes; power of two, divides LANES.
- PIPE_LAT, 2: MAC array latency in cycles from issue to result; ≥1.
- VL_W, 4: width of the vector-length field; must hold LANES.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- validE  in  1  instruction valid in Execute
- vecE  in  1  Execute instruction is a vector op
- accE  in  1  op accumulates across groups (FIR MAC); else element-wise
- vlE  in  VL_W  requested vector length
- unit_ready  in  1  MAC array can accept an issue this cycle
- flush  in  1  hazard/exception flush of Execute
- stallFDE  out  1  hold Fetch, Decode and Execute registers
- unit_start  out  1  issue one lane group to the MAC array
- lane_base  out  VL_W  index of the first element of the issued group
- lane_mask  out  HW_LANES  per-lane enable for the issued group
- acc_clr  out  1  clear the accumulator with this issue
- doneE  out  1  one-cycle pulse; vector result valid, instruction advances
- busy  out  1  sequencer not IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, group counter=0, drain counter=0. All outputs 0.
- Effective length: VL = vlE if 1 ≤ vlE ≤ LANES, else VL = LANES. The clamp applies to vlE=0 and to vlE>LANES. VL is latched on entry to RUN.
- Group count: G = ceil(VL / HW_LANES).
- req = validE & vecE & ~flush.
- IDLE:
  - stallFDE = req (combinational).
  - On req: latch VL and accE, set grp=0, go to RUN.
  - Scalar ops and validE=0 never stall.
- RUN:
  - stallFDE=1.
  - When unit_ready=1: unit_start=1, lane_base=grp*HW_LANES.
  - lane_mask bit i = (lane_base+i < VL).
  - acc_clr=1 only when grp=0 and the latched accE=1.
  - After issuing grp=G-1, load drain counter with PIPE_LAT and go to DRAIN. Otherwise grp++.
  - When unit_ready=0: unit_start=0, lane_mask=0, acc_clr=0, and grp holds.
- DRAIN:
  - stallFDE=1, unit_start=0.
  - Decrement the drain counter each cycle; on reaching 0, go to DONE.
- DONE:
  - doneE=1 and stallFDE=0 for exactly one cycle, so the Execute register advances.
  - Next state is IDLE. The next vector op is seen in IDLE on the following cycle; back-to-back ops cost one extra cycle.
- Latency with unit_ready held at 1: stall cycles = 1 + G + PIPE_LAT, and doneE is on cycle 1 + G + PIPE_LAT.
- flush=1 in any state: next state is IDLE, counters cleared, no doneE. Outputs in the flush cycle are computed as if flush=0, except stallFDE=0.
- lane_base and lane_mask are 0 whenever unit_start=0.
- busy = (state != IDLE).
- Reset mid-operation: aborts immediately. No doneE and no further unit_start.

Decomposition:
- Shared package (simd_pkg):
  - state enum {IDLE, RUN, DRAIN, DONE}.
  - LANES and HW_LANES defaults.
  - Derived constant GRP_W = clog2(LANES/HW_LANES)+1.
- One combinational sub-module, simd_lane_mask_gen: (lane_base, VL) → lane_mask. It is reused by the writeback lane-select logic.

Test Plan:
- Reset, then scalar op (validE=1, vecE=0) → stallFDE=0, busy=0, unit_start never asserted.
- vlE=8, accE=1, unit_ready=1, defaults → stall 7 cycles. lane_base 0,2,4,6 on 4 consecutive cycles, mask=11 each. acc_clr only with base 0. doneE on cycle 7.
- vlE=5 → G=3, bases 0,2,4, masks 11,11,01. vlE=0 → treated as 8 (4 groups).
- unit_ready=0 for 2 cycles while issuing base 2 → base 2 held, no unit_start during the gap. doneE is delayed by exactly 2 cycles (cycle 9).
- flush asserted during DRAIN → IDLE next cycle, no doneE, stallFDE=0 in the flush cycle. A new vector op is then accepted normally.
- rst pulled low mid-RUN (asynchronously, between clock edges) → all outputs 0 immediately. After release, the first vector op starts at lane_base=0.

Source files
------------

// File: rtl/simd_pkg.sv
// Shared constants, state encoding and sizing helper for the SIMD execute sequencer
// and the writeback lane-select logic.
package simd_pkg;

   localparam int unsigned LANES_DEF    = 8;
   localparam int unsigned HW_LANES_DEF = 2;
   localparam int unsigned PIPE_LAT_DEF = 2;
   localparam int unsigned VL_W_DEF     = 4;

   // Group counter width: enough to hold the group count LANES/HW_LANES itself
   function automatic int unsigned grp_w(input int unsigned lanes, input int unsigned hw_lanes);
      return $clog2(lanes / hw_lanes) + 1;
   endfunction

   localparam int unsigned GRP_W = grp_w(LANES_DEF, HW_LANES_DEF);

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE  = 2'd0;
   localparam state_t S_RUN   = 2'd1;
   localparam state_t S_DRAIN = 2'd2;
   localparam state_t S_DONE  = 2'd3;

endpackage

// File: rtl/simd_lane_mask_gen.sv
// Per-lane enable for one lane group: lane i is live when lane_base+i falls inside
// the effective vector length. Shared with the writeback lane-select path.
module simd_lane_mask_gen #(
   parameter int unsigned VL_W     = 4,
   parameter int unsigned HW_LANES = 2
) (
   input  logic [VL_W-1:0]     i_lane_base,
   input  logic [VL_W-1:0]     i_vl,
   output logic [HW_LANES-1:0] o_lane_mask
);

   // One extra bit so lane_base+i cannot wrap past the top element
   for (genvar gi = 0; gi < int'(HW_LANES); gi++) begin : g_lane
      assign o_lane_mask[gi] = (({1'b0, i_lane_base} + (VL_W+1)'(gi)) < {1'b0, i_vl});
   end

endmodule

// File: rtl/simd_exec_sequencer.sv
// Execute-stage sequencer: splits a vector op into HW_LANES-wide groups for the shared
// MAC array, waits out the array latency, then releases the F/D/E stall with doneE.
module simd_exec_sequencer
   import simd_pkg::*;
#(
   parameter int unsigned LANES    = LANES_DEF,
   parameter int unsigned HW_LANES = HW_LANES_DEF,
   parameter int unsigned PIPE_LAT = PIPE_LAT_DEF,
   parameter int unsigned VL_W     = VL_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                validE,
   input  logic                vecE,
   input  logic                accE,
   input  logic [VL_W-1:0]     vlE,
   input  logic                unit_ready,
   input  logic                flush,
   output logic                stallFDE,
   output logic                unit_start,
   output logic [VL_W-1:0]     lane_base,
   output logic [HW_LANES-1:0] lane_mask,
   output logic                acc_clr,
   output logic                doneE,
   output logic                busy
);

   localparam int unsigned    W_GRP    = grp_w(LANES, HW_LANES);
   localparam int unsigned    W_DRN    = $clog2(PIPE_LAT + 1);
   localparam int unsigned    SH       = $clog2(HW_LANES);
   localparam logic [VL_W-1:0]  VL_MAX   = VL_W'(LANES);
   localparam logic [W_DRN-1:0] DRN_INIT = W_DRN'(PIPE_LAT);

   state_t             r_state;
   logic [W_GRP-1:0]   r_grp;
   logic [W_GRP-1:0]   r_last;
   logic [W_DRN-1:0]   r_drn;
   logic [VL_W-1:0]    r_vl;
   logic               r_acc;

   state_t             w_state_nxt;
   logic [W_GRP-1:0]   w_grp_nxt;
   logic [W_GRP-1:0]   w_last_nxt;
   logic [W_DRN-1:0]   w_drn_nxt;
   logic [VL_W-1:0]    w_vl_nxt;
   logic               w_acc_nxt;

   logic               w_req;
   logic [VL_W-1:0]    w_vl_eff;
   logic [VL_W:0]      w_gcnt;
   logic [W_GRP-1:0]   w_last_eff;
   logic [VL_W-1:0]    w_base;
   logic [HW_LANES-1:0] w_mask;

   // rst gates req so the combinational stall stays low while reset is held
   assign w_req      = rst & validE & vecE & ~flush;
   assign w_vl_eff   = ((vlE == '0) || (vlE > VL_MAX)) ? VL_MAX : vlE;
   assign w_gcnt     = ({1'b0, w_vl_eff} + (VL_W+1)'(HW_LANES - 1)) >> SH;
   assign w_last_eff = W_GRP'(w_gcnt - (VL_W+1)'(1));
   assign w_base     = VL_W'(r_grp) << SH;

   simd_lane_mask_gen #(
      .VL_W     (VL_W),
      .HW_LANES (HW_LANES)
   ) u_mask_gen (
      .i_lane_base (w_base),
      .i_vl        (r_vl),
      .o_lane_mask (w_mask)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_grp   <= '0;
         r_last  <= '0;
         r_drn   <= '0;
         r_vl    <= '0;
         r_acc   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_grp   <= w_grp_nxt;
         r_last  <= w_last_nxt;
         r_drn   <= w_drn_nxt;
         r_vl    <= w_vl_nxt;
         r_acc   <= w_acc_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grp_nxt   = r_grp;
      w_last_nxt  = r_last;
      w_drn_nxt   = r_drn;
      w_vl_nxt    = r_vl;
      w_acc_nxt   = r_acc;
      stallFDE    = 1'b0;
      unit_start  = 1'b0;
      acc_clr     = 1'b0;
      doneE       = 1'b0;

      case (r_state)
         S_IDLE: begin
            stallFDE = w_req;
            if (w_req) begin
               w_state_nxt = S_RUN;
               w_grp_nxt   = '0;
               w_vl_nxt    = w_vl_eff;
               w_acc_nxt   = accE;
               w_last_nxt  = w_last_eff;
            end
         end
         S_RUN: begin
            stallFDE   = ~flush;
            unit_start = unit_ready;
            acc_clr    = unit_ready & r_acc & (r_grp == '0);
            if (unit_ready) begin
               if (r_grp == r_last) begin
                  w_state_nxt = S_DRAIN;
                  w_drn_nxt   = DRN_INIT;
               end else begin
                  w_grp_nxt = r_grp + W_GRP'(1);
               end
            end
         end
         S_DRAIN: begin
            stallFDE  = ~flush;
            w_drn_nxt = r_drn - W_DRN'(1);
            if (r_drn == W_DRN'(1)) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            doneE       = ~flush;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Flush abandons the op from any state; outputs above only lose stall and doneE
      if (flush) begin
         w_state_nxt = S_IDLE;
         w_grp_nxt   = '0;
         w_drn_nxt   = '0;
      end
   end

   assign lane_base = unit_start ? w_base : '0;
   assign lane_mask = unit_start ? w_mask : '0;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_simd_exec_sequencer.sv
// Directed + randomized bench for simd_exec_sequencer against a cycle-count reference model.
module tb_simd_exec_sequencer;

   localparam int LANES    = 8;
   localparam int HW       = 2;
   localparam int PL       = 2;
   localparam int VLW      = 4;
   localparam int BUDGET   = 200;

   logic           clk = 1'b0;
   logic           rst;
   logic           validE, vecE, accE, unit_ready, flush;
   logic [VLW-1:0] vlE;
   logic           stallFDE, unit_start, acc_clr, doneE, busy;
   logic [VLW-1:0] lane_base;
   logic [HW-1:0]  lane_mask;

   int n_cmp  = 0;
   int n_fail = 0;

   simd_exec_sequencer #(
      .LANES    (LANES),
      .HW_LANES (HW),
      .PIPE_LAT (PL),
      .VL_W     (VLW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .validE     (validE),
      .vecE       (vecE),
      .accE       (accE),
      .vlE        (vlE),
      .unit_ready (unit_ready),
      .flush      (flush),
      .stallFDE   (stallFDE),
      .unit_start (unit_start),
      .lane_base  (lane_base),
      .lane_mask  (lane_mask),
      .acc_clr    (acc_clr),
      .doneE      (doneE),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_stall"}, 32'(stallFDE),   32'd0);
      chk({tag, "_start"}, 32'(unit_start), 32'd0);
      chk({tag, "_base"},  32'(lane_base),  32'd0);
      chk({tag, "_mask"},  32'(lane_mask),  32'd0);
      chk({tag, "_clr"},   32'(acc_clr),    32'd0);
      chk({tag, "_done"},  32'(doneE),      32'd0);
      chk({tag, "_busy"},  32'(busy),       32'd0);
   endtask

   // Runs one vector op from the IDLE cycle it is presented in. Model: G issues are
   // expected on ready cycles, doneE lands PIPE_LAT+1 cycles after the last issue.
   // fmode 1 flushes on the first drain cycle, fmode 2 flushes on the first RUN cycle.
   task automatic run_op(input logic [VLW-1:0] vl, input logic acc, input int pct,
                         input int gap_at, input int gap_len, input int fmode,
                         input logic keep_valid, output int done_seen);
      int  vle, g, issued, done_c, gap_cnt, base, n;
      logic rdy, fl, es, estall, ebusy, edone, flushed;
      bit  finished;
      vle = (vl == 0 || int'(vl) > LANES) ? LANES : int'(vl);
      g   = (vle + HW - 1) / HW;
      validE = 1'b1; vecE = 1'b1; vlE = vl; accE = acc;
      issued = 0; done_c = -1; gap_cnt = 0; done_seen = -1;
      finished = 0; flushed = 1'b0;
      for (int c = 0; c < BUDGET && !finished; c++) begin
         if (c > 0 && issued < g && issued == gap_at && gap_cnt < gap_len) begin
            rdy = 1'b0;
            gap_cnt++;
         end else begin
            rdy = ($urandom_range(99) < 32'(pct));
         end
         fl = (fmode == 1 && issued == g && done_c >= 0 && c == done_c - PL) ||
              (fmode == 2 && c == 1);
         unit_ready = rdy;
         flush      = fl;
         @(negedge clk);
         if (c == 0) begin
            es = 1'b0; estall = !fl; ebusy = 1'b0; edone = 1'b0;
         end else if (issued < g) begin
            es = rdy;  estall = !fl; ebusy = 1'b1; edone = 1'b0;
         end else if (c < done_c) begin
            es = 1'b0; estall = !fl; ebusy = 1'b1; edone = 1'b0;
         end else begin
            es = 1'b0; estall = 1'b0; ebusy = 1'b1; edone = 1'b1;
         end
         if (doneE === 1'b1) done_seen = c;
         chk("stallFDE",   32'(stallFDE),   32'(estall));
         chk("busy",       32'(busy),       32'(ebusy));
         chk("doneE",      32'(doneE),      32'(edone));
         chk("unit_start", 32'(unit_start), 32'(es));
         if (es) begin
            base = issued * HW;
            n    = (vle - base > HW) ? HW : vle - base;
            chk("lane_base", 32'(lane_base), 32'(base));
            chk("lane_mask", 32'(lane_mask), 32'((1 << n) - 1));
            chk("acc_clr",   32'(acc_clr),   32'(acc && issued == 0));
            issued++;
            if (issued == g) done_c = c + PL + 1;
         end else begin
            chk("idle_base", 32'(lane_base), 32'd0);
            chk("idle_mask", 32'(lane_mask), 32'd0);
            chk("idle_clr",  32'(acc_clr),   32'd0);
         end
         if (fl) flushed = 1'b1;
         if (fl || edone) finished = 1;
         @(posedge clk); #1;
      end
      if (!finished) chk("op_timeout", 32'd0, 32'd1);
      flush = 1'b0;
      if (!keep_valid || flushed) validE = 1'b0;
      if (flushed) begin
         @(negedge clk);
         chk_quiet("after_flush");
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int d;
      logic [VLW-1:0] rvl;
      logic racc, rkeep;
      int rpct, rf;

      // Reset held with a vector op present: everything must stay low
      rst = 1'b0; validE = 1'b1; vecE = 1'b1; accE = 1'b1; vlE = 4'd8;
      unit_ready = 1'b1; flush = 1'b0;
      #3;
      chk_quiet("reset");
      validE = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      // Scalar ops and invalid slots never stall
      for (int i = 0; i < 6; i++) begin
         validE = (i < 4); vecE = (i >= 4); unit_ready = 1'($urandom_range(1));
         @(negedge clk);
         chk_quiet("scalar");
         @(posedge clk); #1;
      end
      validE = 1'b0;

      run_op(4'd8, 1'b1, 100, -1, 0, 0, 1'b0, d);
      chk("done_cycle_vl8", 32'(d), 32'd7);
      run_op(4'd5, 1'b0, 100, -1, 0, 0, 1'b0, d);
      chk("done_cycle_vl5", 32'(d), 32'd6);
      run_op(4'd0, 1'b1, 100, -1, 0, 0, 1'b0, d);
      chk("done_cycle_vl0", 32'(d), 32'd7);
      run_op(4'd13, 1'b0, 100, -1, 0, 0, 1'b0, d);
      chk("done_cycle_vl13", 32'(d), 32'd7);
      run_op(4'd8, 1'b0, 100, 1, 2, 0, 1'b0, d);
      chk("done_cycle_gap", 32'(d), 32'd9);
      run_op(4'd8, 1'b1, 100, -1, 0, 1, 1'b0, d);
      run_op(4'd3, 1'b1, 100, -1, 0, 0, 1'b1, d);
      run_op(4'd1, 1'b1, 100, -1, 0, 0, 1'b0, d);
      chk("done_cycle_b2b_vl1", 32'(d), 32'd4);

      // Asynchronous reset in the middle of RUN
      validE = 1'b1; vecE = 1'b1; vlE = 4'd8; accE = 1'b0; unit_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk_quiet("mid_reset");
      validE = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk_quiet("post_reset_idle");
      @(posedge clk); #1;
      run_op(4'd6, 1'b1, 100, -1, 0, 0, 1'b0, d);
      chk("done_cycle_post_reset", 32'(d), 32'd6);

      // Randomized ops with a stalling MAC array, occasional flushes and back-to-back issue
      for (int k = 0; k < 24; k++) begin
         rvl   = VLW'($urandom_range(15));
         racc  = 1'($urandom_range(1));
         rpct  = int'($urandom_range(100, 40));
         rf    = ($urandom_range(7) == 0) ? 1 : (($urandom_range(7) == 0) ? 2 : 0);
         rkeep = (rf == 0 && k != 23) ? 1'($urandom_range(1)) : 1'b0;
         run_op(rvl, racc, rpct, -1, 0, rf, rkeep, d);
      end

      @(negedge clk);
      chk_quiet("final_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
